seg_scan_n: RTL and testbench



---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_hex_decode.sv | 33 +++
 rtl/seg_scan_n.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_n.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: segment glyphs, the all-dark pattern and the scan state type
// shared by seg_scan_n and its hex decoder.
package seg_pkg;

   typedef enum logic {DEAD = 1'b0, ON = 1'b1} scan_state_e;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-high segment patterns, bit 0 = a ... bit 6 = g.
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-high 7-segment pattern
// (full 0-F, lower-case b and d glyphs).
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   always_comb begin
      // NOTE: default assigned before the case so no path leaves pattern unassigned (no latch).
      pattern = '0;
      case (nibble)
         4'h0: pattern = SEG_0;
         4'h1: pattern = SEG_1;
         4'h2: pattern = SEG_2;
         4'h3: pattern = SEG_3;
         4'h4: pattern = SEG_4;
         4'h5: pattern = SEG_5;
         4'h6: pattern = SEG_6;
         4'h7: pattern = SEG_7;
         4'h8: pattern = SEG_8;
         4'h9: pattern = SEG_9;
         4'hA: pattern = SEG_A;
         4'hB: pattern = SEG_B;
         4'hC: pattern = SEG_C;
         4'hD: pattern = SEG_D;
         4'hE: pattern = SEG_E;
         4'hF: pattern = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg_scan_n.sv
// seg_scan_n: N-digit multiplexed seven-segment scan driver with dead time, blink,
// leading-zero suppression and frame-synchronous updates. SEG_BRIGHT_EN adds a bright[2:0] duty control.
module seg_scan_n
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS      = 6,
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned SCAN_HZ     = 1000,
   parameter int unsigned DEAD_CYCLES = 8,
   parameter int unsigned BLINK_HZ    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] digit_data,
   input  logic [DIGITS-1:0]   dp_mask,
   input  logic [DIGITS-1:0]   blank_mask,
   input  logic [DIGITS-1:0]   blink_mask,
   input  logic                lz_en,
   input  logic                load,
`ifdef SEG_BRIGHT_EN
   input  logic [2:0]          bright,
`endif
   output logic [DIGITS-1:0]   seg_sel,
   output logic [7:0]          seg_led,
   output logic                frame_done
);

   localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned HB  = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned SW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned BW  = (HB > 1) ? $clog2(HB) : 1;

   localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
   localparam logic [SW-1:0] SLOT_ON    = SW'(DEAD_CYCLES);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(HB - 1);

   if (DIGITS == 0 || DIGITS > 8) begin : g_bad_digits
      $error("seg_scan_n: DIGITS must be in 1..8");
   end
   if (DIV < DEAD_CYCLES + 1) begin : g_bad_div
      $error("seg_scan_n: CLK_HZ/SCAN_HZ must be at least DEAD_CYCLES+1");
   end

   typedef struct packed {
      logic [4*DIGITS-1:0] data;
      logic [DIGITS-1:0]   dp;
      logic [DIGITS-1:0]   blank;
      logic [DIGITS-1:0]   blink;
`ifdef SEG_BRIGHT_EN
      logic [2:0]          bright;
`endif
   } disp_t;

   scan_state_e       state, state_next;
   logic [SW-1:0]     slot, slot_next;
   logic [IW-1:0]     idx, idx_next;
   logic [BW-1:0]     blink_cnt;
   logic              blink_ph;
   disp_t             pend, act, capt;
   logic [3:0]        cur_nib;
   logic              cur_dp, cur_dark, zero_above, in_window;
   logic [6:0]        pattern;
   logic [DIGITS-1:0] sel_next;
   logic [7:0]        led_next;

   always_comb begin
      slot_next = slot + SW'(1);
      idx_next  = idx;
      if (slot == SLOT_LAST) begin
         slot_next = '0;
         idx_next  = (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      state_next = (slot_next < SLOT_ON) ? DEAD : ON;
   end

   assign frame_done = (slot == SLOT_LAST) && (idx == IDX_LAST);

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state <= DEAD;
         slot  <= '0;
         idx   <= '0;
      end else begin
         state <= state_next;
         slot  <= slot_next;
         idx   <= idx_next;
      end
   end

   always_comb begin
      capt       = '0;
      capt.data  = digit_data;
      capt.dp    = dp_mask;
      capt.blank = blank_mask;
      capt.blink = blink_mask;
`ifdef SEG_BRIGHT_EN
      capt.bright = bright;
`endif
   end

   // Walk from the top digit down so zero_above covers nibbles i..DIGITS-1.
   always_comb begin
      zero_above = 1'b1;
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_dark   = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (act.data[4*i +: 4] == 4'h0);
         if (IW'(i) == idx) begin
            cur_nib  = act.data[4*i +: 4];
            cur_dp   = act.dp[i];
            cur_dark = act.blank[i] | (act.blink[i] & ~blink_ph)
                     | (lz_en & zero_above & (i != 0));
         end
      end
   end

   seg_hex_decode u_dec (
      .nibble  (cur_nib),
      .pattern (pattern)
   );

   always_comb begin
`ifdef SEG_BRIGHT_EN
      in_window = (32'(slot) - DEAD_CYCLES)
                < (((DIV - DEAD_CYCLES) * (32'(act.bright) + 32'd1)) >> 3);
`else
      in_window = 1'b1;
`endif
      sel_next = '1;
      led_next = SEG_OFF;
      if (state == ON && in_window) begin
         sel_next = ~(DIGITS'(1) << idx);
         if (!cur_dark) led_next = {~cur_dp, ~pattern};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
         // NOTE: display buffers are reset so the first frame shows a defined "0" rather than X.
         pend      <= '0;
         act       <= '0;
         seg_sel   <= '1;
         seg_led   <= SEG_OFF;
      end else begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
         if (frame_done) act <= pend;
         if (load) pend <= capt;
         seg_sel <= sel_next;
         seg_led <= led_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_n.sv
// tb_seg_scan_n: directed bench for seg_scan_n with a position-based behavioural model
// compared every cycle, plus literal spot checks. Honours SEG_BRIGHT_EN.
module tb_seg_scan_n;

   localparam int DIGITS = 6;
   localparam int DIV    = 10;
   localparam int DEAD   = 2;
   localparam int HB     = 20;

   // Active-low glyphs with dp off, indexed by hex value.
   localparam logic [7:0] GLYPH [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic        clk, rst, lz_en, load, frame_done;
   logic [23:0] digit_data;
   logic [5:0]  dp_mask, blank_mask, blink_mask, seg_sel;
   logic [7:0]  seg_led;
`ifdef SEG_BRIGHT_EN
   logic [2:0]  bright;
`endif

   seg_scan_n #(
      .DIGITS(DIGITS), .CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYCLES(DEAD), .BLINK_HZ(25)
   ) dut (
      .clk(clk), .rst(rst), .digit_data(digit_data), .dp_mask(dp_mask),
      .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en), .load(load),
`ifdef SEG_BRIGHT_EN
      .bright(bright),
`endif
      .seg_sel(seg_sel), .seg_led(seg_led), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [23:0] data;
      logic [5:0]  dp, blank, blink;
`ifdef SEG_BRIGHT_EN
      logic [2:0]  br;
`endif
   } m_t;

   m_t         m_pend, m_act;
   bit         m_valid = 1'b0;
   int         p, ms, md;   // p = clock edges since the last reset edge
   logic [5:0] e_sel;
   logic [7:0] e_led;
   logic       e_fd;

   function automatic int lit_cycles();
`ifdef SEG_BRIGHT_EN
      return ((DIV - DEAD) * (int'(m_act.br) + 1)) / 8;
`else
      return DIV - DEAD;
`endif
   endfunction

   function automatic bit model_dark(input int d, input int pos);
      bit          visible_phase = ((pos / HB) % 2) == 0;
      logic [23:0] upper = m_act.data >> (4 * d);
      return m_act.blank[d] || (m_act.blink[d] && !visible_phase) || (lz_en && d > 0 && upper == 24'h0);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b1;
         p = 0;
         m_pend = '0;
         m_act = '0;
         e_sel = 6'h3F;
         e_led = 8'hFF;
         e_fd = 1'b0;
      end else if (m_valid) begin
         ms = p % DIV;
         md = (p / DIV) % DIGITS;
         e_sel = 6'h3F;
         e_led = 8'hFF;
         if (ms >= DEAD && (ms - DEAD) < lit_cycles()) begin
            e_sel = 6'h3F ^ (6'h01 << md);
            if (!model_dark(md, p))
               e_led = GLYPH[m_act.data[4*md +: 4]] & (m_act.dp[md] ? 8'h7F : 8'hFF);
         end
         if (ms == DIV - 1 && md == DIGITS - 1) m_act = m_pend;
         if (load) begin
            m_pend.data = digit_data;
            m_pend.dp = dp_mask;
            m_pend.blank = blank_mask;
            m_pend.blink = blink_mask;
`ifdef SEG_BRIGHT_EN
            m_pend.br = bright;
`endif
         end
         p = p + 1;
         e_fd = (p % DIV == DIV - 1) && ((p / DIV) % DIGITS == DIGITS - 1);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("seg_sel", 32'(seg_sel), 32'(e_sel));
         check("seg_led", 32'(seg_led), 32'(e_led));
         check("frame_done", 32'(frame_done), 32'(e_fd));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_load();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Returns on the negedge inside the frame_done cycle; n = negedges waited.
   task automatic wait_frame(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 200);
      check("frame_wait", 32'(frame_done), 32'd1);
   endtask

   task automatic spot(input string name, input logic [5:0] sel, input logic [7:0] led);
      check({name, "_sel"}, 32'(seg_sel), 32'(sel));
      check({name, "_led"}, 32'(seg_led), 32'(led));
   endtask

   int n, lit_seen, dark_seen;

   initial begin
      rst = 1'b1; load = 1'b0; lz_en = 1'b0;
      digit_data = '0; dp_mask = '0; blank_mask = '0; blink_mask = '0;
`ifdef SEG_BRIGHT_EN
      bright = 3'd7;
`endif
      tick(2);
      spot("reset", 6'h3F, 8'hFF);
      check("reset_fd", 32'(frame_done), 32'd0);
      rst = 1'b0;

      // 1: basic scan of 123456, frame period
      tick(1);
      digit_data = 24'h123456;
      pulse_load();
      wait_frame(n);
      tick(2);  spot("t1_dead", 6'h3F, 8'hFF);
      tick(2);  spot("t1_d0", 6'h3E, 8'h82);
      tick(50); spot("t1_d5", 6'h1F, 8'hF9);
      wait_frame(n);
      wait_frame(n);
      check("frame_period", 32'(n), 32'd60);

      // 2: leading-zero suppression with dp
      tick(1);
      digit_data = 24'h000042; lz_en = 1'b1; dp_mask = 6'b000010;
      pulse_load();
      wait_frame(n);
      tick(4);  spot("t2_d0", 6'h3E, 8'hA4);
      tick(10); spot("t2_d1", 6'h3D, 8'h19);
      tick(10); spot("t2_d2", 6'h3B, 8'hFF);
      tick(30); spot("t2_d5", 6'h1F, 8'hFF);
      tick(1);
      digit_data = 24'h000000; dp_mask = '0;
      pulse_load();
      wait_frame(n);
      tick(4);  spot("t2_zero_d0", 6'h3E, 8'hC0);
      tick(10); spot("t2_zero_d1", 6'h3D, 8'hFF);

      // 3: blink on digits 5 and 4
      tick(1);
      digit_data = 24'h123456; lz_en = 1'b0; blink_mask = 6'b110000;
      pulse_load();
      wait_frame(n);
      tick(4); spot("t3_d0", 6'h3E, 8'h82);
      lit_seen = 0; dark_seen = 0;
      for (int k = 0; k < 360; k++) begin
         @(negedge clk);
         if (seg_sel == 6'h1F) begin
            if (seg_led == 8'hF9) lit_seen++;
            else if (seg_led == 8'hFF) dark_seen++;
         end
      end
      check("blink_lit_seen", 32'(lit_seen > 0), 32'd1);
      check("blink_dark_seen", 32'(dark_seen > 0), 32'd1);

      // 4: tear-free update, mid-frame and coincident loads
      tick(1);
      blink_mask = '0;
      pulse_load();
      wait_frame(n);
      tick(26);
      digit_data = 24'hABCDEF;
      pulse_load();
      tick(7);  spot("t4_old_d3", 6'h37, 8'hB0);
      wait_frame(n);
      tick(34); spot("t4_new_d3", 6'h37, 8'hC6);
      wait_frame(n);
      digit_data = 24'h111111;
      pulse_load();
      tick(3);  spot("t4_coinc_old", 6'h3E, 8'h8E);
      wait_frame(n);
      tick(4);  spot("t4_coinc_new", 6'h3E, 8'hF9);

      // 5: reset during digit 3 ON phase
      wait_frame(n);
      tick(35); spot("t5_pre", 6'h37, 8'hF9);
      rst = 1'b1;
      tick(1);  spot("t5_rst", 6'h3F, 8'hFF);
      rst = 1'b0;
      tick(3);  spot("t5_restart", 6'h3E, 8'hC0);
      wait_frame(n);
      // frame_done lands on position 59, the 60th cycle after the reset edge
      check("rst_frame_pos", 32'(3 + n), 32'd59);

`ifdef SEG_BRIGHT_EN
      // 6: brightness duty
      tick(1);
      digit_data = 24'h123456; bright = 3'd3;
      pulse_load();
      wait_frame(n);
      tick(4); spot("t6_b3_first", 6'h3E, 8'h82);
      tick(3); spot("t6_b3_last", 6'h3E, 8'h82);
      tick(1); spot("t6_b3_off", 6'h3F, 8'hFF);
      tick(1);
      bright = 3'd7;
      pulse_load();
      wait_frame(n);
      tick(4); spot("t6_b7_first", 6'h3E, 8'h82);
      tick(7); spot("t6_b7_last", 6'h3E, 8'h82);
`endif

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
